// File: rtl/uart_tx_if.sv
// Byte-write side and serial/status side of the UART transmitter.
interface uart_tx_if;
    logic [7:0] uart_tx_data;
    logic       uart_tx_wr;
    logic       uart_tx_clr;
    logic       uart_tx_pin;
    logic       uart_tx_full;
    logic       uart_tx_empty;
    logic       uart_tx_busy;
    logic       uart_tx_ovf;

    modport master (
        output uart_tx_data, uart_tx_wr, uart_tx_clr,
        input  uart_tx_pin, uart_tx_full, uart_tx_empty, uart_tx_busy, uart_tx_ovf
    );
    modport slave (
        input  uart_tx_data, uart_tx_wr, uart_tx_clr,
        output uart_tx_pin, uart_tx_full, uart_tx_empty, uart_tx_busy, uart_tx_ovf
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a 4-entry byte FIFO; OVS bclk cycles per bit.
module uart_tx #(
    parameter int OVS       = 8,
    parameter int STOP_BITS = 1
) (
    input  logic   uart_tx_bclk,
    input  logic   uart_tx_rst_n,
    uart_tx_if.slave bus
);
    localparam int CW = $clog2(OVS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          pin_q, pin_d;

    logic [7:0]    mem [4];
    logic [1:0]    wp_q, rp_q;
    logic [2:0]    cnt_q;
    logic          ovf_q;
    logic          full, empty, push, pop, bit_end;

    assign full    = (cnt_q == 3'd4);
    assign empty   = (cnt_q == 3'd0);
    assign push    = bus.uart_tx_wr && !full;
    assign bit_end = (bcnt_q == CW'(OVS - 1));

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        pin_d   = pin_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                bcnt_d = '0;
                pin_d  = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = mem[rp_q];
                    pin_d   = 1'b0;
                    state_d = START;
                end
            end
            START: if (bit_end) begin
                bcnt_d  = '0;
                idx_d   = '0;
                pin_d   = sh_q[0];
                state_d = DATA;
            end
            DATA: if (bit_end) begin
                bcnt_d = '0;
                if (idx_q == 3'd7) begin
                    idx_d   = '0;
                    pin_d   = 1'b1;
                    state_d = STOP;
                end else begin
                    // sh_q[0] is always the bit currently on the line
                    idx_d = idx_q + 3'd1;
                    sh_d  = {1'b0, sh_q[7:1]};
                    pin_d = sh_q[1];
                end
            end
            STOP: if (bit_end) begin
                bcnt_d = '0;
                // idx_q counts stop bits here so bcnt never exceeds OVS-1
                if (idx_q == 3'(STOP_BITS - 1)) begin
                    idx_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = mem[rp_q];
                        pin_d   = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge uart_tx_bclk or negedge uart_tx_rst_n) begin
        if (!uart_tx_rst_n) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            pin_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            pin_q   <= pin_d;
        end
    end

    always_ff @(posedge uart_tx_bclk) begin
        if (push) mem[wp_q] <= bus.uart_tx_data;
    end

    always_ff @(posedge uart_tx_bclk or negedge uart_tx_rst_n) begin
        if (!uart_tx_rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) wp_q <= wp_q + 2'd1;
            if (pop)  rp_q <= rp_q + 2'd1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
            // a dropped write wins over a same-edge clear
            if (bus.uart_tx_wr && full) ovf_q <= 1'b1;
            else if (bus.uart_tx_clr)   ovf_q <= 1'b0;
        end
    end

    assign bus.uart_tx_pin   = pin_q;
    assign bus.uart_tx_full  = full;
    assign bus.uart_tx_empty = empty;
    assign bus.uart_tx_busy  = (state_q != IDLE) || !empty;
    assign bus.uart_tx_ovf   = ovf_q;
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: a line decoder pops expected bytes as frames complete.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed { logic [7:0] d; logic contig; } exp_t;
    exp_t q[$];

    uart_tx_if ba ();
    uart_tx_if bb ();

    uart_tx #(.OVS(8), .STOP_BITS(1)) u_a (
        .uart_tx_bclk (clk),
        .uart_tx_rst_n(rst_n),
        .bus          (ba)
    );
    uart_tx #(.OVS(16), .STOP_BITS(2)) u_b (
        .uart_tx_bclk (clk),
        .uart_tx_rst_n(rst_n),
        .bus          (bb)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr_a(input logic [7:0] d);
        ba.uart_tx_data = d;
        ba.uart_tx_wr   = 1'b1;
        @(posedge clk); #1;
        ba.uart_tx_wr   = 1'b0;
    endtask

    task automatic wait_idle_a(input int lim, output int n);
        n = 0;
        while (ba.uart_tx_busy && n < lim) begin @(posedge clk); #1; n++; end
        chk("idle_timeout", {31'd0, n < lim}, 1);
    endtask

    // Line monitor: samples every negedge, decodes 80-cycle frames, checks shape and order
    logic [79:0] m_s, m_ev;
    logic [7:0]  m_d;
    int          m_st;
    int          m_last_end = -1;
    bit          m_abort;
    exp_t        m_e;

    initial begin : mon
        forever begin
            @(negedge clk);
            if (rst_n && ba.uart_tx_pin === 1'b0) begin
                m_st = cyc;
                m_s = '0;
                m_abort = 1'b0;
                for (int i = 0; i < 80; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst_n) begin m_abort = 1'b1; break; end
                    m_s[i] = ba.uart_tx_pin;
                end
                if (!m_abort) begin
                    for (int b = 0; b < 8; b++) m_d[b] = m_s[8 + 8*b];
                    m_ev = '0;
                    for (int b = 0; b < 8; b++) m_ev[8 + 8*b +: 8] = {8{m_d[b]}};
                    m_ev[79:72] = 8'hFF;
                    chk("frame_shape", {31'd0, m_s === m_ev}, 1);
                    if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_frame: got %0h want none", m_d);
                    end else begin
                        m_e = q.pop_front();
                        chk("rx_byte", m_d, m_e.d);
                        if (m_e.contig) chk("no_gap", m_st, m_last_end);
                    end
                    m_last_end = m_st + 80;
                end else begin
                    m_last_end = -1;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int  n, t0, t_hi, t_end;
    bit  ok;

    initial begin : stim
        ba.uart_tx_data = '0; ba.uart_tx_wr = 1'b0; ba.uart_tx_clr = 1'b0;
        bb.uart_tx_data = '0; bb.uart_tx_wr = 1'b0; bb.uart_tx_clr = 1'b0;

        #12;
        chk("rst_pin",   ba.uart_tx_pin,   1);
        chk("rst_empty", ba.uart_tx_empty, 1);
        chk("rst_full",  ba.uart_tx_full,  0);
        chk("rst_busy",  ba.uart_tx_busy,  0);
        chk("rst_ovf",   ba.uart_tx_ovf,   0);
        @(negedge clk) rst_n = 1'b1;
        idle_cyc(3);
        chk("idle_pin", ba.uart_tx_pin, 1);

        // single byte 0xA3
        q.push_back('{8'hA3, 1'b0});
        wr_a(8'hA3);
        chk("a3_empty_after_wr", ba.uart_tx_empty, 0);
        chk("a3_busy_after_wr",  ba.uart_tx_busy,  1);
        chk("a3_pin_before_pop", ba.uart_tx_pin,   1);
        idle_cyc(1);
        chk("a3_start_pin", ba.uart_tx_pin, 0);
        idle_cyc(79);
        chk("a3_busy_79", ba.uart_tx_busy, 1);
        idle_cyc(1);
        chk("a3_busy_80",  ba.uart_tx_busy,  0);
        chk("a3_empty_80", ba.uart_tx_empty, 1);

        // back-to-back 0x01,0x02,0x03
        idle_cyc(5);
        q.push_back('{8'h01, 1'b0});
        q.push_back('{8'h02, 1'b1});
        q.push_back('{8'h03, 1'b1});
        wr_a(8'h01); wr_a(8'h02); wr_a(8'h03);
        wait_idle_a(400, n);
        chk("b2b_len", n, 239);

        // full / overflow
        idle_cyc(5);
        q.push_back('{8'h10, 1'b0});
        wr_a(8'h10);
        idle_cyc(3);
        for (int k = 1; k <= 4; k++) q.push_back('{8'h10 + 8'(k), 1'b1});
        wr_a(8'h11); wr_a(8'h12); wr_a(8'h13);
        chk("full_after_3", ba.uart_tx_full, 0);
        wr_a(8'h14);
        chk("full_after_4", ba.uart_tx_full, 1);
        chk("ovf_before",   ba.uart_tx_ovf,  0);
        wr_a(8'h15);
        chk("ovf_set",   ba.uart_tx_ovf,  1);
        chk("ovf_full",  ba.uart_tx_full, 1);

        // overflow clear
        ba.uart_tx_clr = 1'b1;
        idle_cyc(1);
        ba.uart_tx_clr = 1'b0;
        chk("clr_alone", ba.uart_tx_ovf, 0);
        ba.uart_tx_clr = 1'b1;
        wr_a(8'h16);
        ba.uart_tx_clr = 1'b0;
        chk("clr_vs_ovf", ba.uart_tx_ovf,  1);
        chk("clr_full",   ba.uart_tx_full, 1);
        ba.uart_tx_clr = 1'b1;
        idle_cyc(1);
        ba.uart_tx_clr = 1'b0;
        chk("clr_again", ba.uart_tx_ovf, 0);
        wait_idle_a(600, n);

        // reset during bit 4 of 0x55 with two bytes queued
        idle_cyc(5);
        wr_a(8'h55); wr_a(8'hAA); wr_a(8'hCC);
        idle_cyc(42);
        chk("pre_rst_busy",  ba.uart_tx_busy,  1);
        chk("pre_rst_empty", ba.uart_tx_empty, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_pin",   ba.uart_tx_pin,   1);
        chk("mid_rst_busy",  ba.uart_tx_busy,  0);
        chk("mid_rst_empty", ba.uart_tx_empty, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (100) begin
            @(posedge clk); #1;
            if (ba.uart_tx_pin !== 1'b1 || ba.uart_tx_busy !== 1'b0) ok = 1'b0;
        end
        chk("post_rst_quiet", {31'd0, ok}, 1);

        // OVS=16, STOP_BITS=2, byte 0x00
        bb.uart_tx_data = 8'h00;
        bb.uart_tx_wr   = 1'b1;
        idle_cyc(1);
        bb.uart_tx_wr   = 1'b0;
        idle_cyc(1);
        chk("b_start_pin", bb.uart_tx_pin, 0);
        t0 = cyc;
        n = 0;
        while (bb.uart_tx_pin !== 1'b1 && n < 400) begin idle_cyc(1); n++; end
        t_hi = cyc;
        n = 0;
        while (bb.uart_tx_busy !== 1'b0 && n < 400) begin idle_cyc(1); n++; end
        t_end = cyc;
        chk("b_low_len",   t_hi - t0,    144);
        chk("b_high_len",  t_end - t_hi, 32);
        chk("b_frame_len", t_end - t0,   176);
        chk("b_end_pin",   bb.uart_tx_pin, 1);

        idle_cyc(5);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
